multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath; it is the producer side of the ALUOp interface that feeds the ALU control decoder. Sequences fetch/decode/execute/memory/writeback per opcode. Drives Moore-style datapath enables, handshakes with a variable-latency memory, and counts retired instructions.

Parameters:
CNT_W, 32, width of instr_retired counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
opcode  in  6  instr[31:26] from IR, sampled in DECODE and MEMADR
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory access request (FETCH, MEMRD, MEMWR)
IorD  out  1  0=PC address, 1=ALUOut address
MemWrite  out  1  memory write strobe
IRWrite  out  1  load IR
RegDst  out  1  0=rt, 1=rd
MemtoReg  out  1  0=ALUOut, 1=MDR
RegWrite  out  1  register file write
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
ALUOp  out  2  00=add, 01=subtract, 10=decode funct
PCSrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
PCWrite  out  1  unconditional PC write
Branch  out  1  PC write qualified by ALU zero (external AND)
state_dbg  out  4  current state encoding
instr_retired  out  CNT_W  retired instruction count
illegal_op  out  1  trap flag (see Optional Feature)

Behaviour:
- States/encoding: IDLE=0 FETCH=1 DECODE=2 MEMADR=3 MEMRD=4 MEMWB=5 MEMWR=6 RTYPE_EX=7 RTYPE_WB=8 BEQ_EX=9 ADDI_EX=10 ADDI_WB=11 J_EX=12 TRAP=13.
- Reset: state=IDLE, instr_retired=0, illegal_op=0. All outputs 0 in IDLE. rst mid-instruction aborts immediately; no pending write completes. IDLE->FETCH next cycle unconditionally.
- Outputs are decoded from state only (plus mem_ready where noted); every output not listed for a state is 0.
- FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; IRWrite=PCWrite=mem_ready. Stay while !mem_ready; ->DECODE when mem_ready.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. opcode 100011/101011->MEMADR, 000000->RTYPE_EX, 000100->BEQ_EX, 001000->ADDI_EX, 000010->J_EX, other->see Optional Feature.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; ->MEMRD if opcode=100011 else MEMWR.
- MEMRD: mem_req=1, IorD=1; wait for mem_ready, then ->MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; ->FETCH.
- MEMWR: mem_req=1, IorD=1, MemWrite=1 (held until mem_ready); ->FETCH on mem_ready.
- RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=10; ->RTYPE_WB. RTYPE_WB: RegWrite=1, RegDst=1, MemtoReg=0; ->FETCH.
- BEQ_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1; ->FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; ->ADDI_WB. ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0; ->FETCH.
- J_EX: PCSrc=10, PCWrite=1; ->FETCH.
- instr_retired increments by 1 on every transition into FETCH from any state except IDLE; wraps modulo 2^CNT_W, no saturation.
- Cycle counts at mem_ready=1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each wait cycle adds 1.

Optional Feature:
ILLEGAL_OP_TRAP_EN defined: unrecognised opcode in DECODE ->TRAP; TRAP drives all datapath outputs 0, illegal_op=1, holds until rst; not counted as retired. Undefined: unrecognised opcode DECODE->FETCH as NOP (counted retired), no TRAP state, illegal_op tied 0.

Test Plan:
- Reset then mem_ready=1, opcode=000000 -> state_dbg 0,1,2,7,8,1; ALUOp=10 in RTYPE_EX; RegWrite=RegDst=1 in RTYPE_WB; instr_retired=1.
- lw (100011), mem_ready low 3 cycles in MEMRD -> state holds 4 for 3 cycles with mem_req=IorD=1; MEMWB has MemtoReg=1; 8 cycles FETCH-to-FETCH.
- sw (101011) -> MemWrite=1 only in MEMWR, held until mem_ready; RegWrite never 1.
- beq (000100) -> BEQ_EX: ALUOp=01, Branch=1, PCSrc=01, PCWrite=0; j (000010) -> PCWrite=1, PCSrc=10.
- rst asserted in MEMWR while mem_ready=0 -> next cycle state=IDLE, all outputs 0, instr_retired=0; counter preset near 2^CNT_W-1 wraps to 0.
- opcode=111111: with ILLEGAL_OP_TRAP_EN -> state 13, illegal_op=1 sticky, counter unchanged; without -> FETCH, counter +1, illegal_op=0.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback per opcode, drives the
// datapath enables and ALUOp, waits on a variable-latency memory and counts
// retired instructions.
// Build option: define ILLEGAL_OP_TRAP_EN to send unrecognised opcodes to a
// sticky TRAP state; otherwise they retire as NOPs and illegal_op is tied 0.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic             PCWrite,
  output logic             Branch,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] instr_retired,
  output logic             illegal_op
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADR   = 4'd3,
    MEMRD    = 4'd4,
    MEMWB    = 4'd5,
    MEMWR    = 4'd6,
    RTYPE_EX = 4'd7,
    RTYPE_WB = 4'd8,
    BEQ_EX   = 4'd9,
    ADDI_EX  = 4'd10,
    ADDI_WB  = 4'd11,
    J_EX     = 4'd12,
    TRAP     = 4'd13
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instr_retired_q;
  logic             retire;

  // Next-state selection from the current state, opcode and memory handshake.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:   state_d = FETCH;
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = RTYPE_EX;
          OP_BEQ:       state_d = BEQ_EX;
          OP_ADDI:      state_d = ADDI_EX;
          OP_J:         state_d = J_EX;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      state_d = TRAP;
`else
          default:      state_d = FETCH;
`endif
        endcase
      end
      MEMADR:   state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    if (mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWR:    if (mem_ready) state_d = FETCH;
      RTYPE_EX: state_d = RTYPE_WB;
      RTYPE_WB: state_d = FETCH;
      BEQ_EX:   state_d = FETCH;
      ADDI_EX:  state_d = ADDI_WB;
      ADDI_WB:  state_d = FETCH;
      J_EX:     state_d = FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
      TRAP:     state_d = TRAP;
`else
      TRAP:     state_d = FETCH;
`endif
      default:  state_d = IDLE;
    endcase
  end

  // An instruction retires when control returns to FETCH from a real
  // instruction state; leaving IDLE and waiting in FETCH do not count.
  assign retire = (state_d == FETCH) && (state_q != IDLE) && (state_q != FETCH);

  // State register and retired-instruction counter (wraps, no saturation).
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q         <= IDLE;
      instr_retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instr_retired_q <= instr_retired_q + CNT_W'(1);
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_op_q;

  // Sticky trap flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)                   illegal_op_q <= 1'b0;
    else if (state_d == TRAP)  illegal_op_q <= 1'b1;
  end

  assign illegal_op = illegal_op_q;
`else
  assign illegal_op = 1'b0;
`endif

  // Moore decode of datapath controls; FETCH strobes IR/PC on mem_ready.
  always_comb begin
    mem_req  = 1'b0;
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSrc    = 2'b00;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE:  ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      RTYPE_EX: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      RTYPE_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BEQ_EX: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
      end
      ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDI_WB: RegWrite = 1'b1;
      J_EX: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_dbg     = state_q;
  assign instr_retired = instr_retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed stimulus with a scoreboard. Each stimulus
// step pushes the expected state/controls/counter for that cycle; a separate
// monitor pops and compares on the falling edge. A 4-bit counter is used so
// the wrap case is reachable quickly.
module tb_multicycle_control;

  localparam int CNT_W = 4;

  localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3, S_MEMRD = 4'd4, S_MEMWB = 4'd5;
  localparam logic [3:0] S_MEMWR = 4'd6, S_RTEX = 4'd7,  S_RTWB = 4'd8;
  localparam logic [3:0] S_BEQ = 4'd9,   S_ADDIEX = 4'd10, S_ADDIWB = 4'd11;
  localparam logic [3:0] S_J = 4'd12,    S_TRAP = 4'd13;

  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic             ALUSrcA, PCWrite, Branch;
  logic [1:0]       ALUSrcB, ALUOp, PCSrc;
  logic [3:0]       state_dbg;
  logic [CNT_W-1:0] instr_retired;
  logic             illegal_op;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .PCWrite(PCWrite), .Branch(Branch), .state_dbg(state_dbg),
    .instr_retired(instr_retired), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Control word order:
  // {mem_req,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc,PCWrite,Branch}
  logic [15:0] act_ctrl;
  assign act_ctrl = {mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                     ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite, Branch};

  typedef struct {
    logic [3:0]       st;
    logic [CNT_W-1:0] cnt;
    logic             ill;
    logic [15:0]      ctrl;
    bit               chk_ctrl;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [3:0]       prev_st = S_IDLE;
  logic [CNT_W-1:0] exp_cnt = '0;

  // Hand-written control table per state.
  function automatic logic [15:0] exp_ctrl(input logic [3:0] s, input logic mr);
    case (s)
      S_FETCH:  return {1'b1, 1'b0, 1'b0, mr,   1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, mr,   1'b0};
      S_DECODE: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
      S_MEMADR: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
      S_MEMRD:  return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
      S_MEMWB:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
      S_MEMWR:  return {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
      S_RTEX:   return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
      S_RTWB:   return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
      S_BEQ:    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0, 1'b1};
      S_ADDIEX: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
      S_ADDIWB: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
      S_J:      return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0};
      default:  return 16'h0000;
    endcase
  endfunction

  // One cycle: drive inputs just after the edge and queue what this cycle must show.
  task automatic step(input logic [5:0] op, input logic mr, input logic r,
                      input logic [3:0] st, input bit chk = 1'b1);
    exp_t e;
    @(posedge clk);
    #1;
    opcode    = op;
    mem_ready = mr;
    rst       = r;
    if (st == S_IDLE) exp_cnt = '0;
    else if (st == S_FETCH && prev_st != S_IDLE && prev_st != S_FETCH) exp_cnt = exp_cnt + 1'b1;
    e.st       = st;
    e.cnt      = exp_cnt;
    e.ill      = (st == S_TRAP);
    e.ctrl     = exp_ctrl(st, mr);
    e.chk_ctrl = chk;
    sb.push_back(e);
    prev_st = st;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare on the falling edge whenever an expectation is queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("state_dbg", {12'h0, state_dbg}, {12'h0, e.st});
        check("instr_retired", {12'h0, instr_retired}, {12'h0, e.cnt});
        check("illegal_op", {15'h0, illegal_op}, {15'h0, e.ill});
        if (e.chk_ctrl) check("ctrl", act_ctrl, e.ctrl);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; opcode = 6'b0; mem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset state, then R-type with immediate memory.
    step(OP_R, 1'b1, 1'b0, S_IDLE);
    step(OP_R, 1'b1, 1'b0, S_FETCH);
    step(OP_R, 1'b1, 1'b0, S_DECODE);
    step(OP_R, 1'b1, 1'b0, S_RTEX);
    step(OP_R, 1'b1, 1'b0, S_RTWB);

    // One fetch wait cycle, then lw with three MEMRD wait cycles.
    step(OP_LW, 1'b0, 1'b0, S_FETCH);
    step(OP_LW, 1'b1, 1'b0, S_FETCH);
    step(OP_LW, 1'b1, 1'b0, S_DECODE);
    step(OP_LW, 1'b1, 1'b0, S_MEMADR);
    step(OP_LW, 1'b0, 1'b0, S_MEMRD);
    step(OP_LW, 1'b0, 1'b0, S_MEMRD);
    step(OP_LW, 1'b0, 1'b0, S_MEMRD);
    step(OP_LW, 1'b1, 1'b0, S_MEMRD);
    step(OP_LW, 1'b1, 1'b0, S_MEMWB);

    // sw with MemWrite held over two wait cycles.
    step(OP_SW, 1'b1, 1'b0, S_FETCH);
    step(OP_SW, 1'b1, 1'b0, S_DECODE);
    step(OP_SW, 1'b1, 1'b0, S_MEMADR);
    step(OP_SW, 1'b0, 1'b0, S_MEMWR);
    step(OP_SW, 1'b0, 1'b0, S_MEMWR);
    step(OP_SW, 1'b1, 1'b0, S_MEMWR);

    // beq, j, addi.
    step(OP_BEQ, 1'b1, 1'b0, S_FETCH);
    step(OP_BEQ, 1'b1, 1'b0, S_DECODE);
    step(OP_BEQ, 1'b1, 1'b0, S_BEQ);
    step(OP_J, 1'b1, 1'b0, S_FETCH);
    step(OP_J, 1'b1, 1'b0, S_DECODE);
    step(OP_J, 1'b1, 1'b0, S_J);
    step(OP_ADDI, 1'b1, 1'b0, S_FETCH);
    step(OP_ADDI, 1'b1, 1'b0, S_DECODE);
    step(OP_ADDI, 1'b1, 1'b0, S_ADDIEX);
    step(OP_ADDI, 1'b1, 1'b0, S_ADDIWB);

    // Unrecognised opcode, then reset back to IDLE.
    step(OP_BAD, 1'b1, 1'b0, S_FETCH);
    step(OP_BAD, 1'b1, 1'b0, S_DECODE);
`ifdef ILLEGAL_OP_TRAP_EN
    step(OP_BAD, 1'b1, 1'b0, S_TRAP);
    step(OP_BAD, 1'b1, 1'b0, S_TRAP);
    step(OP_BAD, 1'b1, 1'b1, S_TRAP);
`else
    step(OP_BAD, 1'b1, 1'b1, S_FETCH);
`endif
    step(OP_J, 1'b1, 1'b0, S_IDLE);

    // Sixteen jumps wrap the 4-bit counter back to 0.
    for (int i = 0; i < 16; i++) begin
      step(OP_J, 1'b1, 1'b0, S_FETCH);
      step(OP_J, 1'b1, 1'b0, S_DECODE);
      step(OP_J, 1'b1, 1'b0, S_J);
    end

    // One beq, then abort a store in MEMWR with reset while memory is busy.
    step(OP_BEQ, 1'b1, 1'b0, S_FETCH);
    step(OP_BEQ, 1'b1, 1'b0, S_DECODE);
    step(OP_BEQ, 1'b1, 1'b0, S_BEQ);
    step(OP_SW, 1'b1, 1'b0, S_FETCH);
    step(OP_SW, 1'b1, 1'b0, S_DECODE);
    step(OP_SW, 1'b1, 1'b0, S_MEMADR);
    step(OP_SW, 1'b0, 1'b1, S_MEMWR, 1'b0);
    step(OP_SW, 1'b0, 1'b0, S_IDLE);
    step(OP_SW, 1'b0, 1'b0, S_FETCH);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
